// File: rtl/exp_request_arbiter.sv
// Round-robin arbiter that time-shares one non-pipelined exp unit between softmax lanes.
// Optional WAIT watchdog is built only when EXP_ARB_TIMEOUT_EN is defined.
module exp_request_arbiter #(
    parameter int data_size            = 32,
    parameter int number_of_requesters = 4,
    parameter int timeout_cycles       = 64
) (
    input  logic                                      clock_i,
    input  logic                                      reset_i,
    input  logic [number_of_requesters-1:0]           req_valid_i,
    input  logic [number_of_requesters*data_size-1:0] req_data_i,
    output logic [number_of_requesters-1:0]           req_ready_o,
    output logic [data_size-1:0]                      exp_data_o,
    output logic                                      exp_data_valid_o,
    input  logic [data_size-1:0]                      exp_result_i,
    input  logic                                      exp_result_valid_i,
    output logic [number_of_requesters-1:0]           resp_valid_o,
    output logic [data_size-1:0]                      resp_data_o,
    output logic                                      busy_o,
    output logic                                      err_o,
    output logic [7:0]                                done_count_o
);

    // state  | meaning
    // IDLE   | no transaction; arbitrate among pending lanes
    // ISSUE  | operand presented to exp unit, winner acknowledged
    // WAIT   | waiting for the exp unit result strobe
    // RESP   | result routed back to the winning lane

    localparam int idx_w = (number_of_requesters > 1) ? $clog2(number_of_requesters) : 1;
    localparam int tmo_w = $clog2(timeout_cycles + 1) + 1;
    localparam logic [number_of_requesters-1:0] lane_one = {{(number_of_requesters-1){1'b0}}, 1'b1};

    if (number_of_requesters < 2 || number_of_requesters > 8) begin : g_bad_lanes
        $error("exp_request_arbiter: number_of_requesters must be 2..8");
    end
    if (timeout_cycles < 1) begin : g_bad_timeout
        $error("exp_request_arbiter: timeout_cycles must be at least 1");
    end

    typedef enum logic [1:0] {
        st_idle  = 2'd0,
        st_issue = 2'd1,
        st_wait  = 2'd2,
        st_resp  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [idx_w-1:0]       ptr_q;
    logic [idx_w-1:0]       winner_q;
    logic [idx_w-1:0]       win_idx;
    logic [idx_w-1:0]       ptr_next;
    logic [idx_w:0]         cand;
    logic                   any_req;
    logic [data_size-1:0]   req_sel;
    logic [data_size-1:0]   operand_q;
    logic [data_size-1:0]   result_q;
    logic [7:0]             done_q;
    logic                   grant;
    logic                   result_take;
    logic                   tmo_hit;

    // Scan from ptr upward (mod N); walking the offsets high-to-low leaves the first hit last.
    always_comb begin
        win_idx = ptr_q;
        any_req = 1'b0;
        cand    = '0;
        for (int i = number_of_requesters - 1; i >= 0; i--) begin
            cand = {1'b0, ptr_q} + (idx_w+1)'(i);
            if (cand >= (idx_w+1)'(number_of_requesters)) begin
                cand = cand - (idx_w+1)'(number_of_requesters);
            end
            if (req_valid_i[cand[idx_w-1:0]]) begin
                win_idx = cand[idx_w-1:0];
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_next = win_idx + idx_w'(1);
        if (win_idx == idx_w'(number_of_requesters - 1)) begin
            ptr_next = '0;
        end
    end

    always_comb begin
        req_sel = '0;
        for (int k = 0; k < number_of_requesters; k++) begin
            if (win_idx == idx_w'(k)) begin
                req_sel = req_data_i[k*data_size +: data_size];
            end
        end
    end

    assign grant       = (state_q == st_idle) && any_req;
    assign result_take = (state_q == st_wait) && exp_result_valid_i;

`ifdef EXP_ARB_TIMEOUT_EN
    logic [tmo_w-1:0] tmo_q;
    logic             err_q;

    // Down-counter loaded during ISSUE so its terminal count lands on the last allowed WAIT cycle.
    assign tmo_hit = (state_q == st_wait) && !exp_result_valid_i && (tmo_q == '0);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == st_issue) begin
                tmo_q <= tmo_w'(timeout_cycles - 1);
            end else if (state_q == st_wait && tmo_q != '0) begin
                tmo_q <= tmo_q - tmo_w'(1);
            end
            if (result_take) begin
                err_q <= 1'b0;
            end else if (tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = (state_q == st_resp) && err_q;
`else
    assign tmo_hit = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            st_idle: begin
                if (any_req) begin
                    state_d = st_issue;
                end
            end
            st_issue: state_d = st_wait;
            st_wait: begin
                if (result_take || tmo_hit) begin
                    state_d = st_resp;
                end
            end
            st_resp: state_d = st_idle;
            default: state_d = st_idle;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= st_idle;
            ptr_q     <= '0;
            winner_q  <= '0;
            operand_q <= '0;
            result_q  <= '0;
            done_q    <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                winner_q  <= win_idx;
                operand_q <= req_sel;
                ptr_q     <= ptr_next;
            end
            // A timed-out transaction returns zero data.
            if (result_take) begin
                result_q <= exp_result_i;
            end else if (tmo_hit) begin
                result_q <= '0;
            end
            if (state_q == st_resp) begin
                done_q <= done_q + 8'd1;
            end
        end
    end

    always_comb begin
        req_ready_o      = '0;
        resp_valid_o     = '0;
        exp_data_valid_o = 1'b0;
        case (state_q)
            st_issue: begin
                req_ready_o      = lane_one << winner_q;
                exp_data_valid_o = 1'b1;
            end
            st_resp: resp_valid_o = lane_one << winner_q;
            default: ;
        endcase
    end

    assign exp_data_o   = operand_q;
    assign resp_data_o  = result_q;
    assign busy_o       = (state_q != st_idle);
    assign done_count_o = done_q;

endmodule

// File: tb/tb_exp_request_arbiter.sv
// Directed and randomized bench for exp_request_arbiter against a transaction-level model.
// Timeout scenarios run only when EXP_ARB_TIMEOUT_EN is defined.
module tb_exp_request_arbiter;

    localparam int ds  = 32;
    localparam int nr  = 4;
    localparam int tmo = 8;

    logic            clock_i = 1'b0;
    logic            reset_i;
    logic [nr-1:0]   req_valid;
    logic [nr*ds-1:0] req_data;
    logic [nr-1:0]   req_ready_o;
    logic [ds-1:0]   exp_data_o;
    logic            exp_data_valid_o;
    logic [ds-1:0]   exp_result;
    logic            exp_result_valid;
    logic [nr-1:0]   resp_valid_o;
    logic [ds-1:0]   resp_data_o;
    logic            busy_o;
    logic            err_o;
    logic [7:0]      done_count_o;

    int          compares = 0;
    int          fails = 0;
    int          ptr_m = 0;
    logic [7:0]  done_m = '0;
    logic [31:0] ops [nr];

    exp_request_arbiter #(
        .data_size(ds),
        .number_of_requesters(nr),
        .timeout_cycles(tmo)
    ) dut (
        .clock_i(clock_i),
        .reset_i(reset_i),
        .req_valid_i(req_valid),
        .req_data_i(req_data),
        .req_ready_o(req_ready_o),
        .exp_data_o(exp_data_o),
        .exp_data_valid_o(exp_data_valid_o),
        .exp_result_i(exp_result),
        .exp_result_valid_i(exp_result_valid),
        .resp_valid_o(resp_valid_o),
        .resp_data_o(resp_data_o),
        .busy_o(busy_o),
        .err_o(err_o),
        .done_count_o(done_count_o)
    );

    always #5 clock_i = ~clock_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        compares++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    // Round-robin rule: first requesting lane at or after the pointer, wrapping.
    function automatic int pick(input logic [nr-1:0] r);
        for (int i = 0; i < nr; i++) begin
            if (r[(ptr_m + i) % nr]) return (ptr_m + i) % nr;
        end
        return -1;
    endfunction

    task automatic do_reset();
        reset_i          = 1'b1;
        req_valid        = '0;
        exp_result_valid = 1'b0;
        step();
        step();
        reset_i = 1'b0;
        ptr_m   = 0;
        done_m  = '0;
        chk("rst_busy", busy_o, 0);
        chk("rst_ready", req_ready_o, 0);
        chk("rst_resp_valid", resp_valid_o, 0);
        chk("rst_issue_valid", exp_data_valid_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_done", done_count_o, 0);
        chk("rst_exp_data", exp_data_o, 0);
        chk("rst_resp_data", resp_data_o, 0);
    endtask

    // One full transaction; reqs is the set of lanes raised this cycle (held lanes keep data).
    task automatic txn(input logic [nr-1:0] reqs, input int lat, input bit deliver,
                       input bit spur, input bit fixed, input logic [31:0] fop,
                       input logic [31:0] fres);
        int          w;
        int          n;
        logic [nr-1:0] oh;
        logic [31:0] res;
        for (int k = 0; k < nr; k++) begin
            if (reqs[k] && !req_valid[k]) ops[k] = fixed ? fop : $urandom;
        end
        req_data         = {ops[3], ops[2], ops[1], ops[0]};
        req_valid        = reqs;
        exp_result_valid = spur;
        exp_result       = $urandom;
        chk("idle_busy", busy_o, 0);
        w     = pick(reqs);
        ptr_m = (w + 1) % nr;
        oh    = nr'(1) << w;
        step();
        chk("ready", req_ready_o, oh);
        chk("issue_valid", exp_data_valid_o, 1);
        chk("issue_data", exp_data_o, ops[w]);
        chk("issue_busy", busy_o, 1);
        chk("issue_resp", resp_valid_o, 0);
        exp_result_valid = spur;
        res = fixed ? fres : $urandom;
        n   = deliver ? lat : tmo;
        for (int i = 0; i < n; i++) begin
            step();
            req_valid        = reqs & ~oh;
            exp_result_valid = deliver && (i == n - 1);
            exp_result       = exp_result_valid ? res : $urandom;
            chk("wait_resp", resp_valid_o, 0);
            chk("wait_ready", req_ready_o, 0);
            chk("wait_issue", exp_data_valid_o, 0);
        end
        step();
        exp_result_valid = 1'b0;
        done_m           = done_m + 8'd1;
        chk("resp_valid", resp_valid_o, oh);
        chk("resp_data", resp_data_o, deliver ? res : 32'd0);
        chk("resp_err", err_o, deliver ? 32'd0 : 32'd1);
        chk("resp_busy", busy_o, 1);
        step();
        chk("done_count", done_count_o, done_m);
        chk("back_idle", busy_o, 0);
        chk("idle_resp", resp_valid_o, 0);
    endtask

    initial begin
        logic [nr-1:0] r;
        reset_i          = 1'b1;
        req_valid        = '0;
        req_data         = '0;
        exp_result       = '0;
        exp_result_valid = 1'b0;
        for (int k = 0; k < nr; k++) ops[k] = '0;
        do_reset();

        // Single request on lane 2, exp unit answers two cycles after issue.
        txn(4'b0100, 2, 1'b1, 1'b0, 1'b1, 32'h3F80_0000, 32'h402D_F854);
        chk("single_done", done_count_o, 1);

        // Contention from a fresh pointer: all lanes keep requesting.
        do_reset();
        for (int g = 0; g < 5; g++) begin
            txn(4'b1111, 1 + (g % 3), 1'b1, 1'b0, 1'b0, '0, '0);
        end
        req_valid = '0;

        // Spurious strobes: pure idle, then during IDLE/ISSUE of a real transaction.
        exp_result_valid = 1'b1;
        exp_result       = 32'hDEAD_BEEF;
        step();
        chk("spur_idle_resp", resp_valid_o, 0);
        chk("spur_idle_busy", busy_o, 0);
        step();
        exp_result_valid = 1'b0;
        chk("spur_idle_done", done_count_o, done_m);
        txn(4'b0010, 3, 1'b1, 1'b1, 1'b0, '0, '0);

        // Reset while waiting: lane 1 granted (pointer moves to 2), then aborted.
        do_reset();
        txn(4'b0010, 1, 1'b1, 1'b0, 1'b0, '0, '0);
        req_valid = 4'b0010;
        ops[1]    = $urandom;
        req_data  = {ops[3], ops[2], ops[1], ops[0]};
        step();
        chk("abort_ready", req_ready_o, 4'b0010);
        req_valid = '0;
        step();
        step();
        reset_i = 1'b1;
        step();
        reset_i          = 1'b0;
        ptr_m            = 0;
        done_m           = '0;
        exp_result_valid = 1'b1;
        exp_result       = 32'h1234_5678;
        chk("abort_busy", busy_o, 0);
        chk("abort_resp", resp_valid_o, 0);
        step();
        exp_result_valid = 1'b0;
        chk("late_result_resp", resp_valid_o, 0);
        step();
        chk("late_result_resp2", resp_valid_o, 0);
        chk("abort_done", done_count_o, 0);
        txn(4'b1010, 2, 1'b1, 1'b0, 1'b0, '0, '0);

`ifdef EXP_ARB_TIMEOUT_EN
        txn(4'b0100, 0, 1'b0, 1'b0, 1'b0, '0, '0);
        txn(4'b0001, tmo, 1'b1, 1'b0, 1'b0, '0, '0);
`endif

        // Counter wrap over 256 randomized transactions.
        do_reset();
        for (int t = 0; t < 256; t++) begin
            r = req_valid | nr'($urandom_range(0, 15));
            if (r == '0) r = nr'(1) << $urandom_range(0, nr - 1);
            txn(r, $urandom_range(1, 4), 1'b1, 1'($urandom_range(0, 1)), 1'b0, '0, '0);
        end
        chk("wrap_done", done_count_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
